// File: rtl/button_pkg.sv
// Shared event type and default sizing for the button event path.
package button_pkg;

  localparam int unsigned BtnIdxW          = 3;
  localparam int unsigned DefaultTickDiv   = 100000;
  localparam int unsigned DefaultFifoDepth = 4;

  typedef struct packed {
    logic [BtnIdxW-1:0] btn;
    logic               press;
  } evt_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous event queue; push is ignored when full, pop is ignored when empty.
module event_fifo
  import button_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultFifoDepth,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  evt_t            din,
  input  logic            pop,
  output evt_t            dout,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  evt_t            mem [DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the read side is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounce tick generator plus round-robin arbiter that turns per-button
// rise/fall pulses into an ordered event queue.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned TICK_DIV   = DefaultTickDiv,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     dbt,
  input  logic [N_BTN-1:0]         rise,
  input  logic [N_BTN-1:0]         fall,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic                     evt_press,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned NSrc  = 2 * N_BTN;
  localparam int unsigned SrcW  = $clog2(NSrc);
  localparam int unsigned BtnW  = $clog2(N_BTN);
  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  logic [TickW-1:0] tick_q;
  logic [NSrc-1:0]  pend_q, pend_d, pulse, gnt_oh;
  logic [SrcW-1:0]  rr_q, rr_d, gnt_idx;
  logic             gnt_valid, drop, ovf_q, ovf_d;
  evt_t             push_evt, head_evt;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;

  assign dbt = (tick_q == TickW'(TICK_DIV - 1));

  // Source s = 2*btn + dir, dir 1 = rise.
  always_comb begin
    pulse = '0;
    for (int unsigned b = 0; b < N_BTN; b++) begin
      pulse[2*b]   = fall[b];
      pulse[2*b+1] = rise[b];
    end
  end

  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NSrc; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= NSrc) idx = idx - NSrc;
        if (!gnt_valid && pend_q[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SrcW'(idx);
        end
      end
    end
    gnt_oh = gnt_valid ? ({{(NSrc-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

  always_comb begin
    pend_d = (pend_q & ~gnt_oh) | pulse;
    // A pulse on the source being granted this cycle is a fresh event, not a drop.
    drop   = |(pulse & pend_q & ~gnt_oh);
    ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    rr_d   = rr_q;
    if (gnt_valid) rr_d = (gnt_idx == SrcW'(NSrc - 1)) ? '0 : gnt_idx + 1'b1;
    push_evt.btn   = BtnIdxW'(gnt_idx[SrcW-1:1]);
    push_evt.press = gnt_idx[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= dbt ? '0 : tick_q + 1'b1;
      pend_q <= pend_d;
      rr_q   <= rr_d;
      ovf_q  <= ovf_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_valid),
    .din   (push_evt),
    .pop   (evt_ready),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid = (fifo_count != '0);
  assign evt_btn   = fifo_empty ? '0 : head_evt.btn[BtnW-1:0];
  assign evt_press = fifo_empty ? 1'b0 : head_evt.press;
  assign overflow  = ovf_q;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter: N_BTN, 4, number of debounced buttons served (2..8).
REQ-002 Parameter: TICK_DIV, 100000, clk cycles per debounce tick (>=2).
REQ-003 Parameter: FIFO_DEPTH, 4, event queue entries (power of 2, >=2).
REQ-004 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: dbt  output  1  debounce tick broadcast to all button debouncers.
REQ-007 Port: rise  input  N_BTN  per-button zero_to_one pulses from debouncers.
REQ-008 Port: fall  input  N_BTN  per-button one_to_zero pulses from debouncers.
REQ-009 Port: evt_valid  output  1  queue head holds an event.
REQ-010 Port: evt_ready  input  1  consumer accepts head this cycle.
REQ-011 Port: evt_btn  output  $clog2(N_BTN)  button index of head event.
REQ-012 Port: evt_press  output  1  1 = press (rise), 0 = release (fall).
REQ-013 Port: overflow  output  1  sticky flag, an event was dropped.
REQ-014 Port: ovf_clr  input  1  clears overflow.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap; dbt SHALL be 1 exactly in the cycle count==TICK_DIV-1.
REQ-016 Sources SHALL be indexed s = 2*btn + dir (dir 1 = rise), 2*N_BTN sources total.
REQ-017 Each source SHALL own a pending bit, set at the edge where its pulse input is 1.
REQ-018 Arbiter SHALL grant at most one pending source per cycle, only when queue count < FIFO_DEPTH.
REQ-019 Grant SHALL be round-robin: first pending index at or above rr_ptr, wrapping; rr_ptr <= granted+1 mod 2*N_BTN on grant, unchanged otherwise.
REQ-020 Granted source SHALL be written to queue and its pending bit cleared at the same edge.
REQ-021 Pulse on a source in the cycle it is granted SHALL leave pending set (new event), no overflow.
REQ-022 Pulse on a source already pending and not granted that cycle SHALL be dropped and set overflow.
REQ-023 Latency, idle system: pulse in cycle 0 -> pending cycle 1 -> queued end of cycle 1 -> evt_valid cycle 2.
REQ-024 Head SHALL pop at edge where evt_valid && evt_ready; evt_btn/evt_press SHALL be stable while evt_valid && !evt_ready.
REQ-025 evt_ready with queue empty SHALL have no effect.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; full queue blocks grants (push not allowed to use same-cycle pop).
REQ-027 ovf_clr SHALL clear overflow unless a drop occurs the same cycle (set wins).
REQ-028 Queue order SHALL be grant order, no reordering.

Reset
REQ-029 While rst=1 at an edge: tick counter 0, dbt 0, all pending 0, rr_ptr 0, queue empty (evt_valid 0, evt_btn 0, evt_press 0), overflow 0.
REQ-030 Reset mid-operation SHALL discard queued and pending events; pulses during rst SHALL be ignored.
REQ-031 First dbt after reset release SHALL occur TICK_DIV cycles after the first non-reset edge.

Structure
REQ-032 Shared package button_pkg SHALL hold evt_t struct {btn index, press} and default TICK_DIV / FIFO_DEPTH constants.
REQ-033 Queue SHALL be sub-module event_fifo (sync, parameter DEPTH, type evt_t, push/pop/full/empty/count).
REQ-034 Arbiter, pending bits, tick counter SHALL be in button_event_arbiter top.

Verification (N_BTN=4, TICK_DIV=4, FIFO_DEPTH=4)
REQ-035 Reset release, no stimulus -> dbt high cycles 3,7,11,...; evt_valid 0; overflow 0.
REQ-036 rise[2] cycle 0, evt_ready=1 -> evt_valid cycle 2 with evt_btn=2, evt_press=1, single cycle.
REQ-037 rise=4'b1111 and fall=4'b1111 one cycle, evt_ready=0 -> 4 events queued in order s=0..3 (btn0 rel, btn0 press, btn1 rel, btn1 press); s4..7 stay pending; release ready -> remaining 4 delivered s4..7; overflow 0.
REQ-038 fall[1] cycles 0 and 1 with queue full -> second pulse dropped, overflow=1; ovf_clr one cycle -> overflow 0.
REQ-039 Three events queued, rst pulse one cycle -> evt_valid 0 next cycle, no stale events after release.
REQ-040 Continuous rise[0]/rise[3] every cycle, evt_ready=1 -> grants alternate btn0/btn3, no source starved.
